mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port N-bit register-file memory. Accepts read/write requests from two clients over valid/ready handshakes, serialises them onto the memory's shared we/addr/write/read port, and returns one response per request, tagged with the requester ID. The block sits between the memory and its clients and is the only driver of the memory's control and data inputs.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_rr.sv | 36 +++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned DataW = 5;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } state_e;

  typedef struct packed {
    logic             we;
    logic [DataW-1:0] addr;
    logic [DataW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/arb_rr.sv
// Two-input one-hot grant generator; MEM_ARB_RR_EN selects round-robin, else fixed priority.
module arb_rr
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0] valid_i,
  input  logic            last_grant_i,
  output logic [NREQ-1:0] grant_o
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_o = '0;
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // On a tie the requester that did not win last time goes first.
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = '0;
    endcase
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    grant_o = '0;
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = 2'b01;
      default: grant_o = '0;
    endcase
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises two requesters onto a single-port memory, one op in flight at a time.
// Build option MEM_ARB_RR_EN: round-robin tie-break instead of fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N = DataW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ-1:0][N-1:0]   req_addr,
  input  logic [NREQ-1:0][N-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic                     rsp_id,
  output logic [N-1:0]             rsp_rdata,
  input  logic                     rsp_ready,
  output logic                     mem_we,
  output logic [N-1:0]             mem_addr,
  output logic [N-1:0]             mem_wdata,
  input  logic [N-1:0]             mem_rdata,
  output logic                     mem_rst
);

  state_e         state_q, state_d;
  req_t           req_q, req_d;
  logic           id_q, id_d;
  logic [N-1:0]   rdata_q, rdata_d;
  logic           first_q, first_d;
  logic [NREQ-1:0] grant;
  logic           last_grant;
  logic           xfer;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;
  assign last_grant   = last_grant_q;
  assign last_grant_d = xfer ? grant[1] : last_grant_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign last_grant = 1'b1;
`endif

  arb_rr u_arb (
    .valid_i      (req_valid),
    .last_grant_i (last_grant),
    .grant_o      (grant)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    id_d      = id_q;
    rdata_d   = rdata_q;
    first_d   = 1'b0;
    req_ready = '0;
    xfer      = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = rdata_q;
    unique case (state_q)
      StIdle: begin
        req_ready = rst ? grant : '0;
        xfer      = |(req_ready & req_valid);
        if (xfer) begin
          id_d        = grant[1];
          req_d.we    = req_we[grant[1]];
          req_d.addr  = req_addr[grant[1]];
          req_d.wdata = req_wdata[grant[1]];
          state_d     = StIssue;
        end
      end
      StIssue: begin
        rdata_d = '0;
        first_d = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        // Memory read data only arrives in the first response cycle; bypass it, then hold it.
        if (first_q && !req_q.we) begin
          rsp_rdata = mem_rdata;
          rdata_d   = mem_rdata;
        end
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      req_q   <= '0;
      id_q    <= 1'b0;
      rdata_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      id_q    <= id_d;
      rdata_q <= rdata_d;
      first_q <= first_d;
    end
  end

  assign mem_we    = (state_q == StIssue) && req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign rsp_id    = id_q;
  assign mem_rst   = !rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural register-file memory attached.
module tb_mem_arbiter;
  localparam int unsigned N = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req_valid, req_we, req_ready;
  logic [1:0][N-1:0]    req_addr, req_wdata;
  logic                 rsp_valid, rsp_id, rsp_ready;
  logic [N-1:0]         rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic                 mem_we, mem_rst;
  logic [N-1:0]         mem [32];
  int                   total = 0;
  int                   bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_rdata (rsp_rdata),
    .rsp_ready (rsp_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rst   (mem_rst)
  );

  always @(posedge clk) begin
    if (mem_rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      mem_rdata <= '0;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end else begin
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic we, input logic [N-1:0] a,
                       input logic [N-1:0] d);
    req_valid[id] = 1'b1;
    req_we[id]    = we;
    req_addr[id]  = a;
    req_wdata[id] = d;
  endtask

  // One full transaction with rsp_ready high; returns what was observed.
  task automatic xfer(input int id, input logic we, input logic [N-1:0] a,
                      input logic [N-1:0] d, output logic [1:0] rdy, output logic v,
                      output logic rid, output logic [N-1:0] rd);
    drive(id, we, a, d);
    @(negedge clk);
    rdy = req_ready;
    tick();
    req_valid[id] = 1'b0;
    tick();
    @(negedge clk);
    v   = rsp_valid;
    rid = rsp_id;
    rd  = rsp_rdata;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; rsp_ready = 1'b1;
    req_valid = 2'b11; req_we = 2'b00; req_addr = '0; req_wdata = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b want=00", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL rst_rsp_id got=%b want=0", rsp_id); end
    total++; if (rsp_rdata !== 5'h00) begin bad++; $display("FAIL rst_rdata got=%h want=00", rsp_rdata); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
    total++; if (mem_addr !== 5'h00) begin bad++; $display("FAIL rst_mem_addr got=%h want=00", mem_addr); end
    total++; if (mem_wdata !== 5'h00) begin bad++; $display("FAIL rst_mem_wdata got=%h want=00", mem_wdata); end
    total++; if (mem_rst !== 1'b1) begin bad++; $display("FAIL rst_mem_rst got=%b want=1", mem_rst); end
    tick();
    rst = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    total++; if (mem_rst !== 1'b0) begin bad++; $display("FAIL rel_mem_rst got=%b want=0", mem_rst); end
    tick();
  endtask

  task automatic test_write_read();
    logic [1:0] rdy; logic v, rid; logic [N-1:0] rd;
    drive(0, 1'b1, 5'd3, 5'h15);
    @(negedge clk);
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL wr_ready got=%b want=01", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL wr_issue_we got=%b want=1", mem_we); end
    total++; if (mem_addr !== 5'd3) begin bad++; $display("FAIL wr_issue_addr got=%h want=03", mem_addr); end
    total++; if (mem_wdata !== 5'h15) begin bad++; $display("FAIL wr_issue_data got=%h want=15", mem_wdata); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_issue_rsp got=%b want=0", rsp_valid); end
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL wr_issue_ready got=%b want=00", req_ready); end
    tick();
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL wr_rsp_valid got=%b want=1", rsp_valid); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL wr_rsp_id got=%b want=0", rsp_id); end
    total++; if (rsp_rdata !== 5'h00) begin bad++; $display("FAIL wr_rsp_rdata got=%h want=00", rsp_rdata); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL wr_rsp_we got=%b want=0", mem_we); end
    total++; if (mem[3] !== 5'h15) begin bad++; $display("FAIL wr_landed got=%h want=15", mem[3]); end
    tick();
    xfer(1, 1'b0, 5'd3, 5'h00, rdy, v, rid, rd);
    total++; if (rdy !== 2'b10) begin bad++; $display("FAIL rd_ready got=%b want=10", rdy); end
    total++; if (v !== 1'b1) begin bad++; $display("FAIL rd_rsp_valid got=%b want=1", v); end
    total++; if (rid !== 1'b1) begin bad++; $display("FAIL rd_rsp_id got=%b want=1", rid); end
    total++; if (rd !== 5'h15) begin bad++; $display("FAIL rd_rdata got=%h want=15", rd); end
  endtask

  task automatic test_tie();
    int n = 0;
    int cyc [8];
    logic gnt [8];
    logic want;
    drive(0, 1'b0, 5'd3, 5'h00);
    drive(1, 1'b0, 5'd3, 5'h00);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready !== 2'b00 && n < 8) begin
        cyc[n] = c;
        gnt[n] = req_ready[1];
        n++;
      end
      if (rsp_valid === 1'b1) begin
        total++; if (rsp_rdata !== 5'h15) begin bad++; $display("FAIL tie_rdata got=%h want=15", rsp_rdata); end
      end
      tick();
    end
    req_valid = 2'b00;
    total++; if (n !== 4) begin bad++; $display("FAIL tie_count got=%0d want=4", n); end
    for (int i = 0; i < n; i++) begin
`ifdef MEM_ARB_RR_EN
      want = (i % 2) == 1;
`else
      want = 1'b0;
`endif
      total++; if (gnt[i] !== want) begin bad++; $display("FAIL tie_grant%0d got=%b want=%b", i, gnt[i], want); end
      total++; if (cyc[i] !== 3 * i) begin bad++; $display("FAIL tie_spacing%0d got=%0d want=%0d", i, cyc[i], 3 * i); end
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    drive(0, 1'b0, 5'd3, 5'h00);
    @(negedge clk);
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL bp_ready got=%b want=01", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    drive(1, 1'b0, 5'd5, 5'h00);
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d got=%b want=1", k, rsp_valid); end
      total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL bp_id%0d got=%b want=0", k, rsp_id); end
      total++; if (rsp_rdata !== 5'h15) begin bad++; $display("FAIL bp_rdata%0d got=%h want=15", k, rsp_rdata); end
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL bp_ready%0d got=%b want=00", k, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", rsp_valid); end
    tick();
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_idle_valid got=%b want=0", rsp_valid); end
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_idle_ready got=%b want=10", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    tick();
    @(negedge clk);
    total++; if (rsp_id !== 1'b1) begin bad++; $display("FAIL bp_next_id got=%b want=1", rsp_id); end
    total++; if (rsp_rdata !== 5'h00) begin bad++; $display("FAIL bp_next_rdata got=%h want=00", rsp_rdata); end
    tick();
  endtask

  task automatic test_reset_midop();
    logic [1:0] rdy; logic v, rid; logic [N-1:0] rd;
    drive(0, 1'b0, 5'd3, 5'h00);
    @(negedge clk);
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL mid_ready got=%b want=01", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++; if (mem_rst !== 1'b1) begin bad++; $display("FAIL mid_mem_rst got=%b want=1", mem_rst); end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_no_rsp%0d got=%b want=0", k, rsp_valid); end
      tick();
    end
    xfer(1, 1'b1, 5'd7, 5'h0a, rdy, v, rid, rd);
    total++; if (rdy !== 2'b10) begin bad++; $display("FAIL mid_wr_ready got=%b want=10", rdy); end
    total++; if (v !== 1'b1 || rid !== 1'b1) begin bad++; $display("FAIL mid_wr_rsp got=%b%b want=11", v, rid); end
    xfer(0, 1'b0, 5'd7, 5'h00, rdy, v, rid, rd);
    total++; if (rd !== 5'h0a) begin bad++; $display("FAIL mid_rd7 got=%h want=0a", rd); end
    total++; if (v !== 1'b1 || rid !== 1'b0) begin bad++; $display("FAIL mid_rd7_rsp got=%b%b want=10", v, rid); end
    xfer(0, 1'b0, 5'd3, 5'h00, rdy, v, rid, rd);
    total++; if (rd !== 5'h00) begin bad++; $display("FAIL mid_rd3_cleared got=%h want=00", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie();
    test_backpressure();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
